// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC and IF/ID register. Optional FETCH_PERF_CNT_EN adds stall/flush counters.
// One instruction per cycle, 1-cycle imem; stall freezes PC and IF/ID and replays the pending fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        halt_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_pc4,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        fetch_vld_q, fetch_vld_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_vld_q, ifid_vld_d;

  logic [31:0] flush_tgt;
  logic        flush_act;

  always_comb begin
    flush_tgt   = flush_target & ~32'h0000_0003;
    // EX is empty while booting, so a flush there cannot be genuine.
    flush_act   = flush && (state_q != S_BOOT);

    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    fetch_vld_d = fetch_vld_q;
    ifid_pc_d   = ifid_pc_q;
    ifid_inst_d = ifid_inst_q;
    ifid_vld_d  = ifid_vld_q;

    if (flush_act) begin
      imem_addr = flush_tgt;
    end else if (stall && fetch_vld_q) begin
      imem_addr = fetch_pc_q;
    end else begin
      imem_addr = pc_q;
    end

    if (state_q == S_BOOT) begin
      fetch_pc_d  = RESET_PC;
      fetch_vld_d = 1'b1;
      pc_d        = RESET_PC + 32'd4;
      state_d     = S_RUN;
    end else if (flush_act) begin
      ifid_vld_d  = 1'b0;
      ifid_inst_d = NOP_INST;
      fetch_pc_d  = flush_tgt;
      fetch_vld_d = 1'b1;
      pc_d        = flush_tgt + 32'd4;
      state_d     = S_RUN;
    end else if (!stall) begin
      if (state_q == S_RUN) begin
        if (fetch_vld_q) begin
          ifid_pc_d   = fetch_pc_q;
          ifid_inst_d = imem_rdata;
          ifid_vld_d  = 1'b1;
        end else begin
          ifid_vld_d  = 1'b0;
          ifid_inst_d = NOP_INST;
        end
        if (halt_req) begin
          fetch_vld_d = 1'b0;
          state_d     = S_HALTED;
        end else begin
          fetch_pc_d  = pc_q;
          fetch_vld_d = 1'b1;
          pc_d        = pc_q + 32'd4;
        end
      end else begin
        ifid_vld_d  = 1'b0;
        ifid_inst_d = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      fetch_vld_q <= 1'b0;
      ifid_pc_q   <= 32'd0;
      ifid_inst_q <= NOP_INST;
      ifid_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      fetch_vld_q <= fetch_vld_d;
      ifid_pc_q   <= ifid_pc_d;
      ifid_inst_q <= ifid_inst_d;
      ifid_vld_q  <= ifid_vld_d;
    end
  end

  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_pc4   = ifid_pc_q + 32'd4;
  assign IF_ID_inst  = ifid_inst_q;
  assign IF_ID_valid = ifid_vld_q;
  assign halted      = (state_q == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !flush && (state_q == S_RUN) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush_act && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst, stall, flush, halt_req;
  logic [31:0] flush_target, imem_addr, imem_rdata;
  logic [31:0] IF_ID_pc, IF_ID_pc4, IF_ID_inst;
  logic        IF_ID_valid, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .flush_target(flush_target), .halt_req(halt_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .IF_ID_pc(IF_ID_pc), .IF_ID_pc4(IF_ID_pc4), .IF_ID_inst(IF_ID_inst),
    .IF_ID_valid(IF_ID_valid), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_state;
  logic [31:0] m_pc, m_fpc, m_ifpc, m_ifinst, m_sc, m_fc;
  logic        m_fvld, m_ifvld;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'h13;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_BOOT; m_pc = RESET_PC; m_fpc = RESET_PC; m_fvld = 1'b0;
    m_ifpc = 32'd0; m_ifinst = NOP_INST; m_ifvld = 1'b0; m_sc = 32'd0; m_fc = 32'd0;
  endtask

  task automatic model_step(input logic s, input logic f, input logic [31:0] t, input logic h);
    logic [31:0] tgt;
    tgt = {t[31:2], 2'b00};
    if (s && !f && m_state == M_RUN && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if (f && m_state != M_BOOT && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    if (m_state == M_BOOT) begin
      m_fpc = RESET_PC; m_fvld = 1'b1; m_pc = RESET_PC + 4; m_state = M_RUN;
    end else if (f) begin
      m_ifvld = 1'b0; m_ifinst = NOP_INST;
      m_fpc = tgt; m_fvld = 1'b1; m_pc = tgt + 4; m_state = M_RUN;
    end else if (!s) begin
      if (m_state == M_RUN) begin
        if (m_fvld) begin
          m_ifpc = m_fpc; m_ifinst = mem_word(m_fpc); m_ifvld = 1'b1;
        end else begin
          m_ifvld = 1'b0; m_ifinst = NOP_INST;
        end
        if (h) begin
          m_fvld = 1'b0; m_state = M_HALT;
        end else begin
          m_fpc = m_pc; m_fvld = 1'b1; m_pc = m_pc + 4;
        end
      end else begin
        m_ifvld = 1'b0; m_ifinst = NOP_INST;
      end
    end
  endtask

  task automatic compare_outputs();
    check("if_pc", IF_ID_pc, m_ifpc);
    check("if_pc4", IF_ID_pc4, m_ifpc + 32'd4);
    check("if_inst", IF_ID_inst, m_ifinst);
    check("if_valid", {31'd0, IF_ID_valid}, {31'd0, m_ifvld});
    check("halted", {31'd0, halted}, {31'd0, (m_state == M_HALT)});
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall", perf_stall_cnt, m_sc);
    check("perf_flush", perf_flush_cnt, m_fc);
`endif
  endtask

  // One clock cycle: drive inputs, check imem_addr, clock, feed memory, check registered outputs.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic [31:0] t, input logic h);
    logic [31:0] exp_addr;
    rst = r; stall = s; flush = f; flush_target = t; halt_req = h;
    #1;
    if (!r && m_state != M_HALT) begin
      if (f && m_state != M_BOOT) exp_addr = {t[31:2], 2'b00};
      else if (s && m_fvld)       exp_addr = m_fpc;
      else                        exp_addr = m_pc;
      check("imem_addr", imem_addr, exp_addr);
    end
    last_addr = imem_addr;
    @(posedge clk);
    #1;
    imem_rdata = mem_word(last_addr);
    if (r) model_reset();
    else   model_step(s, f, t, h);
    compare_outputs();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_target = 32'd0; halt_req = 1'b0;
    imem_rdata = 32'd0; last_addr = 32'd0;
    model_reset();
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("rst_inst", IF_ID_inst, NOP_INST);
    check("rst_pc4", IF_ID_pc4, 32'd4);

    // boot: cycle 0 and 1, first valid instruction in cycle 2
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 32'h0000_0200, 0);
    check("first_pc", IF_ID_pc, 32'd0);
    check("first_inst", IF_ID_inst, 32'h13);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("steady_pc8", IF_ID_pc, 32'd8);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    check("stall_hold", IF_ID_pc, 32'd8);
    step(0, 0, 0, 0, 0);
    check("after_stall", IF_ID_pc, 32'd12);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0103, 0);
    check("flush_bubble", IF_ID_inst, NOP_INST);
    step(0, 0, 0, 0, 0);
    check("flush_tgt", IF_ID_pc, 32'h100);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0103, 0);
    step(0, 0, 0, 0, 0);
    check("fs_tgt", IF_ID_pc, 32'h100);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("halt_set", {31'd0, halted}, 32'd1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0040, 0);
    step(0, 0, 0, 0, 0);
    check("restart", IF_ID_pc, 32'h40);
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 0);
    check("wrap_pc4", IF_ID_pc4, 32'd0);
    step(0, 0, 0, 0, 0);
    check("wrap_pc0", IF_ID_pc, 32'd0);
    step(0, 1, 1, 32'h0000_0080, 1);
    step(1, 1, 1, 32'h0000_0080, 1);
    check("midrst_valid", {31'd0, IF_ID_valid}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic        r, s, f, h;
      logic [31:0] t;
      r = ($urandom_range(99) == 0);
      s = ($urandom_range(3) == 0);
      f = ($urandom_range(9) == 0);
      h = ($urandom_range(29) == 0);
      t = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom();
      step(r, s, f, t, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
